// File: rtl/fp_convert_ctrl.sv
// fp_convert_ctrl: converts a 12-bit two's-complement sample into a
// sign / 3-bit exponent / 4-bit significand triple using a five-state FSM.
module fp_convert_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] D,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        S,
    output logic [2:0]  E,
    output logic [3:0]  F,
    output logic [7:0]  conv_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAG   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    logic [11:0] d_reg;
    logic [11:0] mag;
    logic [2:0]  exp_r;
    logic        sign_r;

    logic [11:0] mag_abs;
    logic [3:0]  f_trunc;
    logic        r_bit;
    logic [3:0]  f_rnd;
    logic [2:0]  e_rnd;

    // Magnitude of the captured sample; the most negative code saturates.
    always_comb begin
        mag_abs = d_reg;
        if (d_reg == 12'h800) begin
            mag_abs = 12'h7FF;
        end else if (d_reg[11]) begin
            mag_abs = (~d_reg) + 12'd1;
        end
    end

    // Round-half-up on the normalised magnitude, with carry into the exponent.
    always_comb begin
        f_trunc = mag[10:7];
        r_bit   = mag[6];
        f_rnd   = f_trunc;
        e_rnd   = exp_r;
        if (r_bit) begin
            if (f_trunc != 4'hF) begin
                f_rnd = f_trunc + 4'd1;
            end else if (exp_r != 3'd7) begin
                f_rnd = 4'b1000;
                e_rnd = exp_r + 3'd1;
            end else begin
                f_rnd = 4'hF;
                e_rnd = 3'd7;
            end
        end
    end

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            S          <= 1'b0;
            E          <= 3'd0;
            F          <= 4'd0;
            conv_count <= 8'd0;
            d_reg      <= 12'd0;
            mag        <= 12'd0;
            exp_r      <= 3'd0;
            sign_r     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_reg    <= D;
                        in_ready <= 1'b0;
                        state    <= MAG;
                    end
                end
                MAG: begin
                    sign_r <= d_reg[11];
                    mag    <= mag_abs;
                    exp_r  <= 3'd7;
                    state  <= NORM;
                end
                NORM: begin
                    if (exp_r == 3'd0 || mag[10]) begin
                        state <= ROUND;
                    end else begin
                        mag   <= {mag[10:0], 1'b0};
                        exp_r <= exp_r - 3'd1;
                    end
                end
                ROUND: begin
                    S         <= sign_r;
                    E         <= e_rnd;
                    F         <= f_rnd;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        conv_count <= conv_count + 8'd1;
                        out_valid  <= 1'b0;
                        in_ready   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_convert_ctrl.sv
// tb_fp_convert_ctrl: randomized and directed checks of fp_convert_ctrl
// against an arithmetic reference of the conversion rules.
module tb_fp_convert_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] D;
    logic        out_valid;
    logic        out_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;
    logic [7:0]  conv_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    fp_convert_ctrl dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .D(D),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S(S),
        .E(E),
        .F(F),
        .conv_count(conv_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: value = F * 2^E, normalised so F's top bit sits at
    // magnitude bit 10 when possible, rounded half-up on the next bit.
    function automatic void ref_conv(input logic [11:0] d,
                                     output logic s,
                                     output logic [2:0] e,
                                     output logic [3:0] f,
                                     output int ncyc);
        int v, m, sh, msb, ee, ff, r;
        v = int'($signed(d));
        s = d[11];
        m = (v < 0) ? -v : v;
        if (m > 2047) m = 2047;
        if (m == 0) begin
            sh = 7;
        end else begin
            msb = 0;
            for (int i = 0; i < 11; i++)
                if (((m >> i) & 1) == 1) msb = i;
            sh = 10 - msb;
            if (sh > 7) sh = 7;
        end
        m  = m << sh;
        ee = 7 - sh;
        ff = (m >> 7) & 15;
        r  = (m >> 6) & 1;
        if (r == 1) begin
            if (ff < 15) ff = ff + 1;
            else if (ee < 7) begin
                ff = 8;
                ee = ee + 1;
            end
        end
        e = ee[2:0];
        f = ff[3:0];
        ncyc = sh + 1;
    endfunction

    task automatic convert(input logic [11:0] d, input int hold,
                           output logic s, output logic [2:0] e,
                           output logic [3:0] f, output int lat,
                           output bit to);
        to = 0;
        s = 0;
        e = 0;
        f = 0;
        D = d;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick;
            lat++;
        end
        if (!out_valid) begin
            to = 1;
            return;
        end
        s = S;
        e = E;
        f = F;
        repeat (hold) tick;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        exp_cnt = 0;
        checks++;
        if ({in_ready, out_valid, S, E, F, conv_count} !==
            {1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b S=%b E=%0d F=%0d cnt=%0d want 1 0 0 0 0 0",
                     in_ready, out_valid, S, E, F, conv_count);
        end
    endtask

    task automatic test_directed;
        logic [11:0] dv[6] = '{12'h1A6, 12'h07E, 12'hFFF, 12'h800, 12'h000, 12'h400};
        logic [7:0]  ws[6] = '{0, 0, 1, 1, 0, 0};
        logic [7:0]  we[6] = '{5, 4, 0, 7, 0, 7};
        logic [7:0]  wf[6] = '{13, 8, 1, 15, 0, 8};
        int          wl[6] = '{6, 8, 11, 4, 11, 4};
        logic s;
        logic [2:0] e;
        logic [3:0] f;
        int lat;
        bit to;
        for (int i = 0; i < 6; i++) begin
            convert(dv[i], 0, s, e, f, lat, to);
            checks++;
            if (to || s !== ws[i][0] || e !== we[i][2:0] || f !== wf[i][3:0]) begin
                errors++;
                $display("FAIL directed d=%h: to=%0d S=%b E=%0d F=%0d want S=%0d E=%0d F=%0d",
                         dv[i], to, s, e, f, ws[i], we[i], wf[i]);
            end
            checks++;
            if (lat != wl[i]) begin
                errors++;
                $display("FAIL latency d=%h: got %0d want %0d", dv[i], lat, wl[i]);
            end
            checks++;
            if (conv_count !== 8'(exp_cnt)) begin
                errors++;
                $display("FAIL count d=%h: got %0d want %0d", dv[i], conv_count, exp_cnt);
            end
        end
    endtask

    task automatic test_stall;
        int lat = 1;
        bit bad = 0;
        D = 12'h400;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            tick;
            lat++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL stall_reach: out_valid=%b want 1", out_valid);
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            D = 12'($urandom);
            tick;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                S !== 1'b0 || E !== 3'd7 || F !== 4'd8 ||
                conv_count !== 8'(exp_cnt))
                bad = 1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_hold: vld=%b rdy=%b S=%b E=%0d F=%0d want 1 0 0 7 8",
                     out_valid, in_ready, S, E, F);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || conv_count !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL stall_release: vld=%b rdy=%b cnt=%0d want 0 1 %0d",
                     out_valid, in_ready, conv_count, exp_cnt);
        end
    endtask

    task automatic test_random;
        logic [11:0] d;
        logic s, rs;
        logic [2:0] e, re;
        logic [3:0] f, rf;
        int lat, nc;
        bit to;
        for (int i = 0; i < 40; i++) begin
            d = 12'($urandom);
            convert(d, int'($urandom_range(0, 3)), s, e, f, lat, to);
            ref_conv(d, rs, re, rf, nc);
            checks++;
            if (to || s !== rs || e !== re || f !== rf || lat != nc + 3) begin
                errors++;
                $display("FAIL random d=%h: to=%0d S=%b E=%0d F=%0d lat=%0d want S=%b E=%0d F=%0d lat=%0d",
                         d, to, s, e, f, lat, rs, re, rf, nc + 3);
            end
        end
        checks++;
        if (conv_count !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL random_count: got %0d want %0d", conv_count, exp_cnt);
        end
    endtask

    task automatic test_reset_midflight;
        bit seen = 0;
        D = 12'h001;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_cnt = 0;
        checks++;
        if ({in_ready, out_valid, S, E, F, conv_count} !==
            {1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 8'd0}) begin
            errors++;
            $display("FAIL midflight_reset: rdy=%b vld=%b S=%b E=%0d F=%0d cnt=%0d want 1 0 0 0 0 0",
                     in_ready, out_valid, S, E, F, conv_count);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (out_valid) seen = 1;
            tick;
        end
        out_ready = 1'b0;
        checks++;
        if (seen || conv_count !== 8'd0) begin
            errors++;
            $display("FAIL midflight_ghost: seen=%0d cnt=%0d want 0 0", seen, conv_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] q[$];
        logic [11:0] dd, d0;
        logic acc, hs, hs_s, rs;
        logic [2:0] hs_e, re;
        logic [3:0] hs_f, rf;
        int nc;
        int done_n = 0;
        int cyc = 0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_cnt = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (done_n < 256 && cyc < 256 * 16) begin
            dd = 12'($urandom);
            D = dd;
            acc = in_ready;
            hs = out_valid;
            hs_s = S;
            hs_e = E;
            hs_f = F;
            if (hs) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_overlap: in_ready=%b want 0 during DONE", in_ready);
                end
            end
            tick;
            cyc++;
            if (acc) q.push_back(dd);
            if (hs) begin
                done_n++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious: result with no pending sample");
                end else begin
                    d0 = q.pop_front();
                    ref_conv(d0, rs, re, rf, nc);
                    if (hs_s !== rs || hs_e !== re || hs_f !== rf) begin
                        errors++;
                        $display("FAIL b2b d=%h: S=%b E=%0d F=%0d want S=%b E=%0d F=%0d",
                                 d0, hs_s, hs_e, hs_f, rs, re, rf);
                    end
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (done_n != 256) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d results want 256", done_n);
        end
        checks++;
        if (conv_count !== 8'd0) begin
            errors++;
            $display("FAIL b2b_wrap: cnt=%0d want 0", conv_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        D = 12'd0;
        test_reset;
        test_directed;
        test_stall;
        test_random;
        test_reset_midflight;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_convert_ctrl.md
FP_CONVERT_CTRL -- requirements
Module: fp_convert_ctrl

Interface
REQ-001 SHALL have no parameters; all widths fixed: D 12 bits, E 3 bits, F 4 bits.
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports listed below.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  D carries a sample to convert.
REQ-006 in_ready  output  1  block can accept a sample; high only in IDLE.
REQ-007 D  input  12  two's-complement sample, D[11] = sign.
REQ-008 out_valid  output  1  S/E/F hold a completed result.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 S  output  1  sign of result.
REQ-011 E  output  3  exponent; value represented = F * 2^E.
REQ-012 F  output  4  significand.
REQ-013 conv_count  output  8  number of results delivered, wraps 255->0.

Function
REQ-014 SHALL implement FSM states IDLE, MAG, NORM, ROUND, DONE, one state per cycle.
REQ-015 IDLE: in_ready=1; on in_valid=1 capture D into internal reg, go MAG; otherwise stay.
REQ-016 MAG (1 cycle): sign reg = D[11]; mag = |D| as 12 bits; D=0x800 saturates mag to 0x7FF; exp reg = 7; go NORM.
REQ-017 NORM: each cycle, if exp==0 or mag[10]==1 go ROUND; else mag <<= 1 (zero fill), exp -= 1, stay; NORM lasts shifts+1 cycles, max 8.
REQ-018 ROUND (1 cycle): f = mag[10:7], r = mag[6]; if r==0 F=f, E=exp; if r==1 and f!=15 F=f+1, E=exp.
REQ-019 ROUND carry: r==1, f==15, exp<7 -> F=4'b1000, E=exp+1; r==1, f==15, exp==7 -> F=15, E=7 (saturate).
REQ-020 ROUND loads S, E, F registers and goes DONE; S/E/F change only in ROUND or reset.
REQ-021 DONE: out_valid=1; S/E/F held stable while out_ready=0; on out_ready=1 increment conv_count, go IDLE.
REQ-022 in_valid ignored outside IDLE; no sample accepted in the same cycle as the DONE handshake; next accept no earlier than the following cycle.
REQ-023 Latency from accept edge to out_valid=1: 3 + (NORM cycles) clocks; D=0x400 -> 4 clocks, D=0x000 -> 11 clocks.
REQ-024 out_valid SHALL be registered, never combinational from in_valid or out_ready.
REQ-025 Zero input: mag 0 shifts to exp 0, result S=0 E=0 F=0.

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE, in_ready=1 the following cycle, out_valid=0, S=0, E=0, F=0, conv_count=0, internal mag/exp/sign cleared.
REQ-027 rst has priority over every other input in any state; a conversion in progress (MAG/NORM/ROUND/DONE) is discarded without an output handshake or count increment.
REQ-028 After rst deasserts, the first accept may occur on the first edge with in_valid=1.

Verification
REQ-029 D=0x1A6 (422), out_ready=1 -> S=0 E=5 F=13; out_valid 6 clocks after accept; conv_count 0->1.
REQ-030 D=0x07E (126) -> round carry: S=0 E=4 F=8; D=0xFFF (-1) -> S=1 E=0 F=1.
REQ-031 D=0x800 (-2048) -> saturation: S=1 E=7 F=15; D=0x000 -> S=0 E=0 F=0 after 11 clocks.
REQ-032 D=0x400, out_ready=0 for 5 cycles -> out_valid stays 1, S=0 E=7 F=8 stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle, count +1.
REQ-033 Accept D=0x001, assert rst during 3rd NORM cycle -> next cycle IDLE, out_valid=0, S/E/F/conv_count=0; no result ever emitted for that sample.
REQ-034 256 back-to-back conversions with in_valid and out_ready held 1 -> conv_count wraps to 0; each result matches a reference model of REQ-016..019.
